// File: rtl/alu_sub_arbiter_if.sv
// alu_sub_arbiter_if
//   Bundles the request/response signals of the shared subtract unit.
//   master : requester side. It drives valids, operands and S bits, and
//            receives grants, responses and flags.
//   slave  : arbiter side. It is the mirror of master.
//   Signals:
//     req_valid[1:0] / req_ready[1:0] : per-requester request handshake.
//     In1_0, In2_0, S_0               : requester 0 operands and set-flags bit.
//     In1_1, In2_1, S_1               : requester 1 operands and set-flags bit.
//     rsp_valid[1:0]                  : one-cycle response pulse to the owner.
//     Result, New_Flag                : registered difference and its NZCV.
//     Flag                            : architectural NZCV register.
//     busy                            : a response is in the output stage.
interface alu_sub_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] In1_0;
  logic [WIDTH-1:0] In2_0;
  logic [WIDTH-1:0] In1_1;
  logic [WIDTH-1:0] In2_1;
  logic             S_0;
  logic             S_1;
  logic [1:0]       rsp_valid;
  logic [WIDTH-1:0] Result;
  logic [3:0]       New_Flag;
  logic [3:0]       Flag;
  logic             busy;

  modport master (
    output req_valid, In1_0, In2_0, In1_1, In2_1, S_0, S_1,
    input  req_ready, rsp_valid, Result, New_Flag, Flag, busy
  );

  modport slave (
    input  req_valid, In1_0, In2_0, In1_1, In2_1, S_0, S_1,
    output req_ready, rsp_valid, Result, New_Flag, Flag, busy
  );
endinterface

// File: rtl/alu_sub_arbiter.sv
// alu_sub_arbiter
//   Two requesters share one WIDTH-bit subtractor that also generates NZCV.
//   One request is granted per cycle. The difference and its flags are
//   registered, and one cycle later they are returned with a rsp_valid pulse
//   on the owner's bit. The architectural Flag register is written only by
//   granted ops that have S=1.
//
//   Handshake: a request transfers on a cycle where req_valid[i] & req_ready[i]
//   is high. req_ready is combinational, at most one bit is set, and it is
//   never set for an idle requester or while rst is high. Responses cannot be
//   back-pressured, so requesters must sample in the cycle rsp_valid is high.
//
//   Ports:
//     clk       : rising-edge clock.
//     rst       : synchronous, active-high reset.
//     bus       : alu_sub_arbiter_if.slave (the request/response bundle).
//     dbg_state : output-stage FSM state (0 = IDLE, 1 = RESP).
//
//   Configuration macro ALU_ARB_FIXED_PRIO_EN:
//     defined   : fixed priority. Requester 0 wins a tie, and requester 1
//                 can starve.
//     undefined : round-robin with a one-bit priority pointer.
module alu_sub_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  alu_sub_arbiter_if.slave  bus,
  output logic              dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [1:0]       grant;
  logic [1:0]       owner_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       new_flag_q;
  logic [3:0]       flag_q;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_s;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] diff;
  logic [3:0]       flags;

  // ---------------------------------------------------------------------------
  // Arbitration. Grants are forced low during reset, so an op presented in the
  // reset cycle is never accepted and produces no response.
  // ---------------------------------------------------------------------------
`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = 2'b00;
    if (!rst) begin
      if (bus.req_valid[0])      grant = 2'b01;
      else if (bus.req_valid[1]) grant = 2'b10;
    end
  end
`else
  // prio names the requester that wins a tie. It moves to the loser after
  // every grant and holds when nothing is granted.
  logic prio_q;

  always_comb begin
    grant = 2'b00;
    if (!rst) begin
      case (bus.req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else if (grant[0]) begin
      prio_q <= 1'b1;
    end else if (grant[1]) begin
      prio_q <= 1'b0;
    end
  end
`endif

  assign bus.req_ready = grant;

  // ---------------------------------------------------------------------------
  // Shared subtract datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    op_a = grant[1] ? bus.In1_1 : bus.In1_0;
    op_b = grant[1] ? bus.In2_1 : bus.In2_0;
    op_s = grant[1] ? bus.S_1   : bus.S_0;
  end

  // The extra top bit of the extended subtraction is the unsigned borrow.
  // ARM carry is the inverse of that borrow.
  assign diff_ext = {1'b0, op_a} - {1'b0, op_b};
  assign diff     = diff_ext[WIDTH-1:0];

  assign flags = {
    diff[WIDTH-1],
    (diff == '0),
    ~diff_ext[WIDTH],
    (op_a[WIDTH-1] ^ op_b[WIDTH-1]) & (diff[WIDTH-1] ^ op_a[WIDTH-1])
  };

  // ---------------------------------------------------------------------------
  // Output-stage FSM. Any grant loads the stage and moves to RESP, so the
  // stage can turn over every cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = IDLE;
    if (|grant) state_d = RESP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= 2'b00;
      result_q   <= '0;
      new_flag_q <= 4'b0000;
      flag_q     <= 4'b0000;
    end else begin
      state_q <= state_d;
      if (|grant) begin
        owner_q    <= grant;
        result_q   <= diff;
        new_flag_q <= flags;
        if (op_s) flag_q <= flags;
      end
    end
  end

  assign bus.rsp_valid = (state_q == RESP) ? owner_q : 2'b00;
  assign bus.busy      = (state_q == RESP);
  assign bus.Result    = result_q;
  assign bus.New_Flag  = new_flag_q;
  assign bus.Flag      = flag_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_sub_arbiter.sv
module tb_alu_sub_arbiter;

  logic clk;
  logic rst;
  logic dbg_state;

  int errors;
  int checks;

  alu_sub_arbiter_if #(.WIDTH(32)) bus ();

  alu_sub_arbiter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v,
                       input logic [31:0] a0, input logic [31:0] b0, input logic s0,
                       input logic [31:0] a1, input logic [31:0] b1, input logic s1);
    bus.req_valid = v;
    bus.In1_0 = a0; bus.In2_0 = b0; bus.S_0 = s0;
    bus.In1_1 = a1; bus.In2_1 = b1; bus.S_1 = s1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. The subtract and flags are computed with plain unsigned
  // and 64-bit signed arithmetic.
  // ---------------------------------------------------------------------------
  int         m_turn;
  logic [31:0] m_result;
  logic [3:0]  m_nf;
  logic [3:0]  m_flag;
  logic [1:0]  m_rsp;
  logic        m_busy;

  function automatic logic [35:0] ref_sub(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sd;
    logic [31:0] r;
    logic n, z, c, v;
    sa = $signed(a);
    sb = $signed(b);
    sd = sa - sb;
    r  = a - b;
    n  = r[31];
    z  = (r == 32'd0);
    c  = (a >= b);
    v  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    return {n, z, c, v, r};
  endfunction

  function automatic int pick_grant(input logic [1:0] v);
    if (v == 2'b00) return -1;
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    return 0;
`else
    return m_turn;
`endif
  endfunction

  function automatic logic [1:0] onehot(input int g);
    if (g == 0) return 2'b01;
    if (g == 1) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_turn = 0; m_result = 0; m_nf = 0; m_flag = 0; m_rsp = 0; m_busy = 0;
  endtask

  task automatic model_step(input logic r, input logic [1:0] v,
                            input logic [31:0] a0, input logic [31:0] b0, input logic s0,
                            input logic [31:0] a1, input logic [31:0] b1, input logic s1,
                            output int g);
    logic [35:0] x;
    if (r) begin
      g = -1;
      model_reset();
      return;
    end
    g = pick_grant(v);
    if (g < 0) begin
      m_rsp = 2'b00;
      m_busy = 1'b0;
    end else begin
      x = (g == 1) ? ref_sub(a1, b1) : ref_sub(a0, b0);
      m_result = x[31:0];
      m_nf = x[35:32];
      if ((g == 1) ? s1 : s0) m_flag = m_nf;
      m_rsp = onehot(g);
      m_busy = 1'b1;
      m_turn = 1 - g;
    end
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(2'b11, 32'd9, 32'd1, 1'b1, 32'd9, 32'd2, 1'b1);
    #1;
    checks++;
    if (bus.req_ready !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b exp 00", bus.req_ready);
    end
    tick();
    tick();
    checks++;
    if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0 || dbg_state !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: rsp=%b busy=%b state=%b exp 00/0/0",
                         bus.rsp_valid, bus.busy, dbg_state);
    end
    checks++;
    if (bus.Result !== 32'd0 || bus.New_Flag !== 4'd0 || bus.Flag !== 4'd0) begin
      errors++; $display("FAIL reset_data: res=%h nf=%b flag=%b exp 0/0000/0000",
                         bus.Result, bus.New_Flag, bus.Flag);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(2'b00, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_flags();
    logic [1:0]  v_t   [5] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b01};
    logic [31:0] a_t   [5] = '{32'd5, 32'd3, 32'd7, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [31:0] b_t   [5] = '{32'd3, 32'd5, 32'd7, 32'd1, 32'hFFFF_FFFF};
    logic        s_t   [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] res_t [5] = '{32'd2, 32'hFFFF_FFFE, 32'd0, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [3:0]  nf_t  [5] = '{4'b0010, 4'b1000, 4'b0110, 4'b0011, 4'b1001};
    logic [3:0]  fl_t  [5] = '{4'b0010, 4'b1000, 4'b1000, 4'b0011, 4'b1001};
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (v_t[k] == 2'b01) drive(v_t[k], a_t[k], b_t[k], s_t[k], 0, 0, 0);
      else                 drive(v_t[k], 0, 0, 0, a_t[k], b_t[k], s_t[k]);
      tick();
      @(negedge clk);
      drive(2'b00, 0, 0, 0, 0, 0, 0);
      #1;
      checks++;
      if (bus.rsp_valid !== v_t[k] || bus.Result !== res_t[k]) begin
        errors++; $display("FAIL flags_res[%0d]: rsp=%b res=%h exp %b %h",
                           k, bus.rsp_valid, bus.Result, v_t[k], res_t[k]);
      end
      checks++;
      if (bus.New_Flag !== nf_t[k] || bus.Flag !== fl_t[k]) begin
        errors++; $display("FAIL flags_nzcv[%0d]: nf=%b flag=%b exp %b %b",
                           k, bus.New_Flag, bus.Flag, nf_t[k], fl_t[k]);
      end
      tick();
      checks++;
      if (bus.rsp_valid !== 2'b00 || bus.Result !== res_t[k] || bus.Flag !== fl_t[k]) begin
        errors++; $display("FAIL flags_hold[%0d]: rsp=%b res=%h flag=%b exp 00 %h %b",
                           k, bus.rsp_valid, bus.Result, bus.Flag, res_t[k], fl_t[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] a0, b0, a1, b1;
    logic [1:0]  exp_rsp;
    logic [35:0] x;
    int g;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      a0 = 32'd100 + 32'(k); b0 = 32'(k);
      a1 = 32'd50;          b1 = 32'd60 + 32'(k);
`ifdef ALU_ARB_FIXED_PRIO_EN
      g = 0;
`else
      g = k % 2;
`endif
      @(negedge clk);
      drive(2'b11, a0, b0, 1'b0, a1, b1, 1'b0);
      #1;
      checks++;
      if (bus.req_ready !== onehot(g)) begin
        errors++; $display("FAIL b2b_grant[%0d]: got %b exp %b", k, bus.req_ready, onehot(g));
      end
      x = (g == 1) ? ref_sub(a1, b1) : ref_sub(a0, b0);
      exp_q.push_back(x[31:0]);
      exp_rsp = onehot(g);
      tick();
      checks++;
      if (bus.rsp_valid !== exp_rsp || exp_q.size() == 0 || bus.Result !== exp_q[0]) begin
        errors++; $display("FAIL b2b_rsp[%0d]: rsp=%b res=%h exp %b %h",
                           k, bus.rsp_valid, bus.Result, exp_rsp, exp_q[0]);
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    @(negedge clk);
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: rsp=%b busy=%b exp 00 0", bus.rsp_valid, bus.busy);
    end
  endtask

  task automatic test_reset_mid_op();
    apply_reset();
    // Grant in the reset cycle must be discarded.
    @(negedge clk);
    rst = 1'b1;
    drive(2'b01, 32'd5, 32'd3, 1'b1, 0, 0, 0);
    #1;
    checks++;
    if (bus.req_ready !== 2'b00) begin
      errors++; $display("FAIL rstop_ready: got %b exp 00", bus.req_ready);
    end
    tick();
    @(negedge clk);
    rst = 1'b0;
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (bus.rsp_valid !== 2'b00 || bus.Flag !== 4'd0 || bus.Result !== 32'd0) begin
      errors++; $display("FAIL rstop_nogrant: rsp=%b flag=%b res=%h exp 00 0000 0",
                         bus.rsp_valid, bus.Flag, bus.Result);
    end
    // A pending response is cancelled by reset.
    @(negedge clk);
    drive(2'b10, 0, 0, 0, 32'd1, 32'd2, 1'b1);
    tick();
    @(negedge clk);
    rst = 1'b1;
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0 || bus.Flag !== 4'd0) begin
      errors++; $display("FAIL rstop_cancel: rsp=%b busy=%b flag=%b exp 00 0 0000",
                         bus.rsp_valid, bus.busy, bus.Flag);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_stream();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(2'b10, 0, 0, 0, 32'd10 * 32'(k + 1), 32'd3, 1'b0);
      #1;
      checks++;
      if (bus.req_ready !== 2'b10) begin
        errors++; $display("FAIL single_ready[%0d]: got %b exp 10", k, bus.req_ready);
      end
      tick();
      checks++;
      if (bus.busy !== 1'b1 || bus.rsp_valid !== 2'b10 || dbg_state !== 1'b1 ||
          bus.Result !== 32'd10 * 32'(k + 1) - 32'd3) begin
        errors++; $display("FAIL single_busy[%0d]: busy=%b rsp=%b state=%b res=%h", k,
                           bus.busy, bus.rsp_valid, dbg_state, bus.Result);
      end
    end
    @(negedge clk);
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if (bus.busy !== 1'b0 || dbg_state !== 1'b0) begin
      errors++; $display("FAIL single_idle: busy=%b state=%b exp 0 0", bus.busy, dbg_state);
    end
  endtask

  task automatic test_random();
    logic        r, s0, s1;
    logic [1:0]  v;
    logic [31:0] a0, b0, a1, b1;
    int g;
    apply_reset();
    model_reset();
    for (int i = 0; i < 300; i++) begin
      r  = ($urandom_range(0, 24) == 0);
      v  = 2'($urandom_range(0, 3));
      a0 = rand_op(); b0 = rand_op(); s0 = 1'($urandom_range(0, 1));
      a1 = rand_op(); b1 = rand_op(); s1 = 1'($urandom_range(0, 1));
      @(negedge clk);
      rst = r;
      drive(v, a0, b0, s0, a1, b1, s1);
      model_step(r, v, a0, b0, s0, a1, b1, s1, g);
      #1;
      checks++;
      if (bus.req_ready !== onehot(g)) begin
        errors++; $display("FAIL rand_ready[%0d]: got %b exp %b (v=%b rst=%b)",
                           i, bus.req_ready, onehot(g), v, r);
      end
      tick();
      checks++;
      if (bus.rsp_valid !== m_rsp || bus.busy !== m_busy) begin
        errors++; $display("FAIL rand_ctrl[%0d]: rsp=%b busy=%b exp %b %b",
                           i, bus.rsp_valid, bus.busy, m_rsp, m_busy);
      end
      checks++;
      if (bus.Result !== m_result || bus.New_Flag !== m_nf || bus.Flag !== m_flag) begin
        errors++; $display("FAIL rand_data[%0d]: res=%h nf=%b flag=%b exp %h %b %b",
                           i, bus.Result, bus.New_Flag, bus.Flag, m_result, m_nf, m_flag);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    drive(2'b00, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    drive(2'b00, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_flags();
    test_back_to_back();
    test_reset_mid_op();
    test_single_stream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
